// File: rtl/board_store.sv
// board_store: playfield storage for a 20x12 Tetris board.
//
// Game logic writes/clears cells, clears the whole board, or requests removal
// of full lines through a valid/ready command port. The display side sees a
// frame-stable snapshot (data_o) that is only refreshed on a frame strobe while
// idle, or at the end of a line-clear sweep if a strobe arrived during it.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   cmd_valid_i    command present
//   cmd_ready_o    command can be accepted this cycle (idle only)
//   cmd_op_i       0 set cell, 1 clear cell, 2 clear full lines, 3 clear board
//   cmd_row_i      row index for ops 0/1 (row 0 = top)
//   cmd_col_i      column index for ops 0/1 (col 0 = left)
//   frame_start_i  one-cycle strobe at start of vertical blanking
//   data_o         displayed snapshot; cell (r,c) is bit CELLS-1-COLS*r-c
//   busy_o         line-clear sweep in progress
//   clr_done_o     one-cycle pulse in the last cycle of a sweep
//   clr_count_o    full lines removed by the last sweep (saturates at 7)
module board_store #(
    parameter int ROWS = 20,
    parameter int COLS = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [4:0]           cmd_row_i,
    input  logic [3:0]           cmd_col_i,
    input  logic                 frame_start_i,
    output logic [ROWS*COLS-1:0] data_o,
    output logic                 busy_o,
    output logic                 clr_done_o,
    output logic [2:0]           clr_count_o
);

    localparam int CELLS = ROWS * COLS;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FILL,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CELLS-1:0]   board_q, board_d;
    logic [CELLS-1:0]   data_q, data_d;
    logic               pend_q, pend_d;
    logic [4:0]         rd_q, rd_d;
    logic [4:0]         wr_q, wr_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [2:0]         clr_count_q, clr_count_d;
    logic [COLS-1:0]    rd_row;

    // Bit index of the leftmost cell of row r.
    function automatic logic [7:0] row_top(input logic [4:0] r);
        return 8'(CELLS - 1 - COLS * int'(r));
    endfunction

    function automatic logic [7:0] cell_idx(input logic [4:0] r, input logic [3:0] c);
        return 8'(CELLS - 1 - COLS * int'(r) - int'(c));
    endfunction

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        data_d      = data_q;
        pend_d      = pend_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        clr_count_d = clr_count_q;
        rd_row      = board_q[row_top(rd_q) -: COLS];

        case (state_q)
            IDLE: begin
                // Snapshot takes the board as it was before this edge's command.
                if (frame_start_i) begin
                    data_d = board_q;
                end
                if (cmd_valid_i) begin
                    case (cmd_op_i)
                        2'd0, 2'd1: begin
                            if (cmd_row_i < 5'(ROWS) && cmd_col_i < 4'(COLS)) begin
                                board_d[cell_idx(cmd_row_i, cmd_col_i)] = (cmd_op_i == 2'd0);
                            end
                        end
                        2'd2: begin
                            state_d = SCAN;
                            rd_d    = 5'(ROWS - 1);
                            wr_d    = 5'(ROWS - 1);
                            cnt_d   = 3'd0;
                        end
                        default: begin
                            board_d = '0;
                        end
                    endcase
                end
            end

            SCAN: begin
                if (frame_start_i) begin
                    pend_d = 1'b1;
                end
                // Full rows are dropped; surviving rows are copied down to wr.
                if (&rd_row) begin
                    cnt_d = sat_inc(cnt_q);
                end else begin
                    board_d[row_top(wr_q) -: COLS] = rd_row;
                    wr_d = wr_q - 5'd1;
                end
                rd_d = rd_q - 5'd1;
                if (rd_q == 5'd0) begin
                    if (cnt_d != 3'd0) begin
                        state_d = FILL;
                    end else begin
                        state_d     = DONE;
                        clr_count_d = cnt_d;
                    end
                end
            end

            FILL: begin
                if (frame_start_i) begin
                    pend_d = 1'b1;
                end
                board_d[row_top(wr_q) -: COLS] = '0;
                if (wr_q == 5'd0) begin
                    state_d     = DONE;
                    clr_count_d = cnt_q;
                end else begin
                    wr_d = wr_q - 5'd1;
                end
            end

            default: begin
                // Board is fully compacted here, so a strobe landing in this
                // cycle can be served directly as well.
                if (pend_q || frame_start_i) begin
                    data_d = board_q;
                end
                pend_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            board_q     <= '0;
            data_q      <= '0;
            pend_q      <= 1'b0;
            rd_q        <= 5'd0;
            wr_q        <= 5'd0;
            cnt_q       <= 3'd0;
            clr_count_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            data_q      <= data_d;
            pend_q      <= pend_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            clr_count_q <= clr_count_d;
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign clr_done_o  = (state_q == DONE);
    assign clr_count_o = clr_count_q;
    assign data_o      = data_q;

endmodule

// File: tb/tb_board_store.sv
module tb_board_store;
    localparam int ROWS = 20;
    localparam int COLS = 12;
    localparam int N    = ROWS * COLS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'd0;
    logic [4:0]   cmd_row = 5'd0;
    logic [3:0]   cmd_col = 4'd0;
    logic         frame_start = 1'b0;
    logic [N-1:0] data;
    logic         busy;
    logic         clr_done;
    logic [2:0]   clr_count;

    board_store #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_row_i    (cmd_row),
        .cmd_col_i    (cmd_col),
        .frame_start_i(frame_start),
        .data_o       (data),
        .busy_o       (busy),
        .clr_done_o   (clr_done),
        .clr_count_o  (clr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] cnt;
        int         due;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every clr_done pulse must match the oldest expected sweep.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && clr_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected got=pulse@%0d exp=none", cyc);
            end else begin
                e = sb.pop_front();
                chk("clr_count", N'(clr_count), N'(e.cnt));
                chk("done_cycle", N'(cyc), N'(e.due));
            end
        end
    end

    function automatic logic [N-1:0] cellv(input int r, input int c);
        return N'(1) << (N - 1 - COLS * r - c);
    endfunction

    function automatic logic [N-1:0] rowv(input int r, input logic [11:0] p);
        return N'(p) << (N - COLS * (r + 1));
    endfunction

    // Called and returns on a negedge; acc is the number of the accepting posedge.
    task automatic issue(input logic [1:0] op, input int r, input int c, input bit fs,
                         output int acc, output int waits);
        cmd_op = op;
        cmd_row = 5'(r);
        cmd_col = 4'(c);
        cmd_valid = 1'b1;
        waits = 0;
        while (!cmd_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got=ready0 exp=ready1");
        end
        frame_start = fs;
        acc = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic cmd(input logic [1:0] op, input int r, input int c);
        int a, w;
        issue(op, r, c, 1'b0, a, w);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got=busy exp=idle");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, w, a2, n;
        bit hold_ok;
        logic [N-1:0] base, expv;
        logic [11:0] pats [4];
        pats[0] = 12'b000001100000;
        pats[1] = 12'b000011110000;
        pats[2] = 12'b001111111100;
        pats[3] = 12'b111111111111;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_data", data, '0);
        chk("rst_ready", N'(cmd_ready), N'(1));
        chk("rst_busy", N'(busy), N'(0));
        chk("rst_done", N'(clr_done), N'(0));
        chk("rst_count", N'(clr_count), N'(0));
        rst = 1'b0;

        cmd(2'd0, 19, 0);
        repeat (2) @(negedge clk);
        chk("pre_strobe_data", data, '0);
        pulse_frame();
        chk("bit11_snapshot", data, N'(1) << 11);

        // Same-edge ordering
        cmd(2'd3, 0, 0);
        issue(2'd0, 0, 0, 1'b1, a, w);
        chk("same_edge_bit239", N'(data[N-1]), N'(0));
        chk("same_edge_data", data, '0);
        pulse_frame();
        chk("second_snapshot", data, cellv(0, 0));

        // Out-of-range commands
        cmd(2'd3, 0, 0);
        issue(2'd0, 20, 3, 1'b0, a, w);
        chk("oor_row_wait", N'(w), N'(0));
        issue(2'd0, 5, 12, 1'b0, a, w);
        chk("oor_col_wait", N'(w), N'(0));
        pulse_frame();
        chk("oor_snapshot", data, '0);

        // Triangle compaction
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < COLS; c++)
                if (pats[i][11-c]) cmd(2'd0, 16 + i, c);
        issue(2'd2, 0, 0, 1'b0, a, w);
        sb.push_back('{3'd1, a + 22 - 1});
        chk("tri_busy", N'(busy), N'(1));
        wait_idle();
        pulse_frame();
        expv = rowv(17, pats[0]) | rowv(18, pats[1]) | rowv(19, pats[2]);
        chk("tri_snapshot", data, expv);

        // Deferred snapshot
        cmd(2'd3, 0, 0);
        for (int c = 0; c < COLS; c++) begin
            cmd(2'd0, 18, c);
            cmd(2'd0, 19, c);
        end
        cmd(2'd0, 10, 4);
        pulse_frame();
        base = data;
        chk("defer_base", base, rowv(18, 12'hFFF) | rowv(19, 12'hFFF) | cellv(10, 4));
        issue(2'd2, 0, 0, 1'b0, a, w);
        sb.push_back('{3'd2, a + 23 - 1});
        n = 0;
        hold_ok = 1'b1;
        while (!cmd_ready && n < 100) begin
            if (data !== base) hold_ok = 1'b0;
            frame_start = (n == 3 || n == 6);
            @(negedge clk);
            n++;
        end
        frame_start = 1'b0;
        chk("defer_data_hold", N'(hold_ok), N'(1));
        chk("defer_ready_low", N'(n), N'(23));
        chk("defer_snapshot", data, cellv(12, 4));

        // Reset mid-sweep
        for (int c = 0; c < COLS; c++) cmd(2'd0, 19, c);
        cmd(2'd0, 5, 5);
        issue(2'd2, 0, 0, 1'b0, a, w);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", N'(cmd_ready), N'(1));
        chk("midrst_busy", N'(busy), N'(0));
        chk("midrst_data", data, '0);
        pulse_frame();
        chk("midrst_board", data, '0);

        // Back-pressure: op 3 held during a sweep
        cmd(2'd0, 3, 3);
        issue(2'd2, 0, 0, 1'b0, a, w);
        sb.push_back('{3'd0, a + 21 - 1});
        issue(2'd3, 0, 0, 1'b0, a2, w);
        chk("held_accept_edge", N'(a2), N'(a + 22));
        chk("held_ready", N'(cmd_ready), N'(1));
        chk("held_busy", N'(busy), N'(0));
        pulse_frame();
        chk("held_clear", data, '0);
        cmd(2'd0, 3, 3);
        pulse_frame();
        chk("after_held", data, cellv(3, 3));

        repeat (3) @(negedge clk);
        chk("sb_empty", N'(sb.size()), N'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/board_store.md
# board_store

Playfield storage for the 20x12 Tetris board, sitting between game logic and the VGA pattern generator. Game logic writes or clears cells and requests full-line removal through a valid/ready command port. The block presents a frame-stable 240-bit snapshot on `data`, the same bit layout the display path consumes. The snapshot is refreshed only on a frame strobe, and never while a line-clear sweep is in progress, so the display never shows a half-compacted board.

## Interface
- ROWS, 20, board height (row 0 = top)
- COLS, 12, board width (col 0 = left)
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  2  0 = set cell, 1 = clear cell, 2 = clear full lines, 3 = clear board
- cmd_row  in  5  row index for ops 0/1
- cmd_col  in  4  column index for ops 0/1
- frame_start  in  1  one-cycle strobe at start of vertical blanking
- data  out  240  displayed snapshot; row r occupies bits [239-12r -: 12]; cell (r,c) is bit 239-12r-c
- busy  out  1  line-clear sweep in progress
- clr_done  out  1  one-cycle pulse when a sweep finishes
- clr_count  out  3  full lines removed by last sweep (0..4 in play; saturates at 7)

## Operation
- Internal live board: 240 bits, same layout as `data`.
- A command is accepted on a clock edge where cmd_valid && cmd_ready.
- Op 0 / op 1 set / clear cell (cmd_row, cmd_col) at the accepting edge. If cmd_row ≥ 20 or cmd_col ≥ 12, the command is accepted with no board change.
- Op 3 zeroes the live board at the accepting edge.
- Op 2 starts the sweep FSM. cmd_ready = 0 in every state except IDLE.
- FSM states:
  - IDLE
    - Op 2 accepted -> SCAN, with rd = 19, wr = 19, cnt = 0.
  - SCAN, one row per cycle:
    - If row rd is all ones, cnt++ (saturating at 7) and wr holds.
    - Otherwise row wr <= row rd and wr--.
    - Then rd--.
    - After processing rd = 0: go to FILL if cnt > 0, else DONE.
  - FILL
    - Row wr <= 0 and wr-- each cycle, until row 0 has been zeroed; then -> DONE.
  - DONE, one cycle
    - clr_done = 1 and clr_count <= cnt.
    - If a snapshot is pending, copy it here.
    - -> IDLE.
- Copy to self (rd == wr) is permitted and harmless.
- Snapshot rule:
  - On frame_start with FSM in IDLE: data <= live board, taking the value before any command accepted on the same edge.
  - On frame_start with FSM not in IDLE: set `pending`.
  - In DONE with `pending`: data <= compacted board, then clear `pending`.
  - Multiple frame_starts during a sweep collapse into one pending copy.
- busy = 1 in SCAN, FILL and DONE.

## Timing
- Reset values: board = 0, data = 0, pending = 0, FSM = IDLE, cmd_ready = 1, busy = 0, clr_done = 0, clr_count = 0.
- Reset mid-sweep: all of the above apply at the next edge; the partial sweep is discarded.
- Ops 0, 1, 3: single-cycle.
  - Live board updates at the accepting edge.
  - The change reaches `data` at the first frame_start edge strictly after acceptance.
- Op 2 latency, acceptance edge to the clr_done cycle, with k = lines removed:
  - k = 0: 21 cycles (20 SCAN + 1 DONE).
  - k > 0: 21 + k cycles.
  - cmd_ready returns to 1 the cycle after DONE.
- `data` changes only on a frame_start edge in IDLE, or in the DONE cycle. It is constant at all other times.
- cmd_valid may be held high while cmd_ready = 0. The command is taken on the first edge where cmd_ready = 1, with no loss and no duplication.

## Test plan
- Reset
  - Stimulus: assert rst for 2 cycles, then set cell (19,0) and pulse frame_start 3 cycles later.
  - Response: data = 0 before the strobe; after it, only bit 11 is 1.
- Same-edge ordering
  - Stimulus: op 0 at (0,0) on the same edge as frame_start, then frame_start again.
  - Response: first snapshot has bit 239 = 0; second has bit 239 = 1.
- Out-of-range command
  - Stimulus: op 0 with (20,3), then op 0 with (5,12).
  - Response: each accepted in one cycle; board unchanged; next snapshot = 0.
- Triangle compaction
  - Stimulus: load rows 16..19 = 000001100000, 000011110000, 001111111100, 111111111111; issue op 2.
  - Response: clr_done 22 cycles after acceptance with clr_count = 1; next snapshot has rows 17..19 = 000001100000, 000011110000, 001111111100 and row 16 = 0.
- Deferred snapshot
  - Stimulus: board with rows 18 and 19 full plus cell (10,4) set; op 2; pulse frame_start twice during SCAN.
  - Response: data unchanged until the DONE cycle; there it shows only cell (12,4); clr_count = 2; cmd_ready held 0 for 23 cycles.
- Reset mid-sweep and back-pressure
  - Stimulus: assert rst at cycle 10 of a sweep. Then hold cmd_valid with op 3 high during a new sweep.
  - Response: after the reset, board = 0 and FSM = IDLE. The held op 3 is accepted exactly once, the cycle after clr_done.
